// File: rtl/aes_seq_if.sv
// aes_seq_if: control/status bundle between a block controller and aes_round_sequencer
interface aes_seq_if;
  logic       start, abort, decrypt, ctr_mode;
  logic [1:0] key_size;
  logic [3:0] round, col_en;
  logic [1:0] col_idx;
  logic       key_gen, add_rk_only, bypass_mix, busy, done, iv_cnt_en;
  modport master (
    output start, abort, key_size, decrypt, ctr_mode,
    input  round, col_en, col_idx, key_gen, add_rk_only, bypass_mix, busy, done, iv_cnt_en
  );
  modport slave (
    input  start, abort, key_size, decrypt, ctr_mode,
    output round, col_en, col_idx, key_gen, add_rk_only, bypass_mix, busy, done, iv_cnt_en
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: AES round / column-phase control FSM; CTR support when AES_CTR_EN is defined
module aes_round_sequencer #(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic      clk,
  input logic      rst,
  aes_seq_if.slave b
);
  localparam int C = COLS_PER_CYCLE;
  localparam int P = 4 / C;
  localparam logic [1:0] PL = 2'(P - 1);
  typedef enum logic [2:0] {IDLE, INIT, KEY, COL, DONE} state_t;
  state_t     st, st_n;
  logic [1:0] ph, ph_n, ks, ks_n, k;
  logic [3:0] rd, rd_n, nr, nr_n;
  logic       rev, rev_n, ctr, ctr_n, ctr_sel, accept, cols;
  function automatic logic [3:0] nr_of(input logic [1:0] s);
    return s == 2'd0 ? 4'd10 : s == 2'd1 ? 4'd12 : 4'd14;
  endfunction
`ifdef AES_CTR_EN
  assign ctr_sel = b.ctr_mode;
`else
  logic ctr_unused;
  assign ctr_sel    = 1'b0;
  assign ctr_unused = b.ctr_mode;
`endif
  assign nr      = nr_of(ks);
  assign b.round = rd;
  always_comb begin
    st_n   = st;
    ph_n   = ph;
    rd_n   = rd;
    ks_n   = ks;
    rev_n  = rev;
    ctr_n  = ctr;
    accept = st == IDLE && b.start && !b.abort && b.key_size != 2'b11;
    if (b.abort && st != IDLE) begin
      st_n = IDLE;
      ph_n = '0;
      rd_n = '0;
    end else if (accept) begin
      st_n  = INIT;
      ks_n  = b.key_size;
      rev_n = b.decrypt & ~ctr_sel;
      ctr_n = ctr_sel;
    end else if (st == KEY) begin
      st_n = COL;
    end else if (st == DONE) begin
      st_n = IDLE;
      rd_n = '0;
    end else if (st == INIT || st == COL) begin
      ph_n = ph == PL ? 2'd0 : ph + 2'd1;
      if (ph == PL) begin
        st_n = (st == INIT || rd < nr) ? KEY : DONE;
        rd_n = st_n == KEY ? rd + 4'd1 : rd;
      end
    end
    nr_n = nr_of(ks_n);
    k    = rev_n ? PL - ph_n : ph_n;
    cols = st_n == INIT || st_n == COL;
  end
  // Outputs are registered from next-state values so they line up with the state they describe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st            <= IDLE;
      ph            <= '0;
      rd            <= '0;
      ks            <= '0;
      rev           <= 1'b0;
      ctr           <= 1'b0;
      b.col_en      <= '0;
      b.col_idx     <= '0;
      b.key_gen     <= 1'b0;
      b.add_rk_only <= 1'b0;
      b.bypass_mix  <= 1'b0;
      b.busy        <= 1'b0;
      b.done        <= 1'b0;
      b.iv_cnt_en   <= 1'b0;
    end else begin
      st            <= st_n;
      ph            <= ph_n;
      rd            <= rd_n;
      ks            <= ks_n;
      rev           <= rev_n;
      ctr           <= ctr_n;
      b.col_en      <= cols ? 4'(((1 << C) - 1) << (int'(k) * C)) : 4'd0;
      b.col_idx     <= cols ? 2'(int'(k) * C) : 2'd0;
      b.key_gen     <= st_n == KEY;
      b.add_rk_only <= st_n == INIT;
      b.bypass_mix  <= (st_n == KEY || st_n == COL) && rd_n == nr_n;
      b.busy        <= st_n == INIT || st_n == KEY || st_n == COL;
      b.done        <= st_n == DONE;
      b.iv_cnt_en   <= st_n == DONE && ctr_n;
    end
endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1, gives the state columns processed per cycle; it SHALL take only the values 1, 2 or 4.
REQ-002 Local constant P = 4/COLS_PER_CYCLE, the number of column phases per round.
REQ-003 clk  in  1  sole clock; all flops rise on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  request to start a block; sampled only in IDLE.
REQ-006 abort  in  1  synchronous cancel of the current block.
REQ-007 key_size  in  2  00=AES-128 (Nr=10), 01=AES-192 (Nr=12), 10=AES-256 (Nr=14), 11=reserved.
REQ-008 decrypt  in  1  1=inverse cipher column order.
REQ-009 ctr_mode  in  1  CTR mode request; used only when REQ-032 is compiled in.
REQ-010 round  out  4  current round number.
REQ-011 col_en  out  4  one-hot-group column write enables.
REQ-012 col_idx  out  2  lowest enabled column index.
REQ-013 key_gen  out  1  round-key generation strobe.
REQ-014 add_rk_only  out  1  high during round 0 (AddRoundKey only).
REQ-015 bypass_mix  out  1  high in the last round (MixColumns bypassed).
REQ-016 busy / done / iv_cnt_en  out  1 each  block in progress / one-cycle completion pulse / counter-increment pulse.

Function
REQ-017 The FSM SHALL have states IDLE, INIT, KEY, COL and DONE.
REQ-018 In IDLE, when start=1, abort=0 and key_size!=11, the block SHALL latch key_size, decrypt and ctr_mode and go to INIT; start with key_size=11 SHALL be ignored.
REQ-019 INIT SHALL last P cycles with add_rk_only=1 and round=0, then go to KEY.
REQ-020 KEY SHALL last 1 cycle with key_gen=1 and col_en=0; round SHALL increment on the edge entering KEY.
REQ-021 COL SHALL last P cycles; it SHALL go to KEY if round<Nr, else to DONE.
REQ-022 DONE SHALL last 1 cycle with done=1, then go to IDLE with round cleared to 0.
REQ-023 Phase k (0..P-1) of INIT/COL SHALL enable col_en bits [k*C +: C], where C=COLS_PER_CYCLE, when encrypting; decrypting SHALL use phase order P-1..0.
REQ-024 busy SHALL be 1 in INIT, KEY and COL, else 0; bypass_mix SHALL be 1 in KEY and COL when round==Nr.
REQ-025 Latency: with the accepting edge counted as edge 0, done SHALL be high after edge P+Nr*(P+1) (P=4, Nr=10: 54).
REQ-026 start while busy SHALL be ignored, and input changes while busy SHALL NOT affect the running block.
REQ-027 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge with round=0 and no done pulse; in IDLE, abort SHALL override start.
REQ-028 round SHALL never exceed Nr, and no counter SHALL wrap.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, round=0 and all outputs to 0, including in mid-block.
REQ-030 After rst is released, the first start SHALL behave as in REQ-018, with no residual state.

Configuration
REQ-031 Macro AES_CTR_EN selects CTR support.
REQ-032 With AES_CTR_EN defined, a latched ctr_mode=1 SHALL force the encrypt column order regardless of decrypt, and SHALL pulse iv_cnt_en for 1 cycle coincident with done.
REQ-033 Without AES_CTR_EN, ctr_mode SHALL be ignored and iv_cnt_en SHALL be tied to 0.

Verification
REQ-034 P=4, key_size=00, decrypt=0, start pulse -> done after edge 54; round sequence 0 then 1..10; col_en per cycle 0001,0010,0100,1000; bypass_mix only in round 10.
REQ-035 P=1, key_size=10, decrypt=1 -> col_en=1111 in every INIT/COL cycle; 14 key_gen pulses; done after edge 29.
REQ-036 P=2, key_size=01, decrypt=1 -> col_en order 1100 then 0011; done after edge 38.
REQ-037 abort in round 5 COL, then start on the next cycle -> no done for the first block; second block completes at full latency; rst asserted mid-block -> all outputs 0 at once.
REQ-038 key_size=11 with start -> busy stays 0; start while busy -> ignored, single done pulse.
REQ-039 AES_CTR_EN defined, ctr_mode=1, decrypt=1 -> encrypt column order and iv_cnt_en=1 only in the done cycle; macro undefined -> iv_cnt_en constant 0.
